// File: rtl/pb_uart_rx_if.sv
// Processor-side port bundle of the PicoBlaze UART receiver.
// Optional parity signals are present only when PB_UART_RX_PARITY_EN is defined.
interface pb_uart_rx_if #(
    parameter int unsigned FIFO_AW = 4
) ();
    logic               uart_rx_read;
    logic               uart_rx_clear;
    logic [7:0]         uart_rx_data;
    logic               uart_rx_int;
    logic [FIFO_AW:0]   uart_rx_count;
    logic               uart_rx_empty;
    logic               uart_rx_full;
    logic               uart_rx_overrun;
    logic               uart_rx_frame_err;
`ifdef PB_UART_RX_PARITY_EN
    logic               uart_rx_parity_odd;
    logic               uart_rx_parity_err;

    modport master (
        output uart_rx_read, uart_rx_clear, uart_rx_parity_odd,
        input  uart_rx_data, uart_rx_int, uart_rx_count, uart_rx_empty, uart_rx_full,
               uart_rx_overrun, uart_rx_frame_err, uart_rx_parity_err
    );

    modport slave (
        input  uart_rx_read, uart_rx_clear, uart_rx_parity_odd,
        output uart_rx_data, uart_rx_int, uart_rx_count, uart_rx_empty, uart_rx_full,
               uart_rx_overrun, uart_rx_frame_err, uart_rx_parity_err
    );
`else
    modport master (
        output uart_rx_read, uart_rx_clear,
        input  uart_rx_data, uart_rx_int, uart_rx_count, uart_rx_empty, uart_rx_full,
               uart_rx_overrun, uart_rx_frame_err
    );

    modport slave (
        input  uart_rx_read, uart_rx_clear,
        output uart_rx_data, uart_rx_int, uart_rx_count, uart_rx_empty, uart_rx_full,
               uart_rx_overrun, uart_rx_frame_err
    );
`endif
endinterface

// File: rtl/pb_uart_rx.sv
// PicoBlaze UART receive stage: 16x-oversampled 8N1 deframer feeding a FWFT byte FIFO.
// Define PB_UART_RX_PARITY_EN to add a parity bit (8-P-1) with a sticky parity error flag.
module pb_uart_rx #(
    parameter int unsigned FIFO_AW   = 4,
    parameter int unsigned INT_LEVEL = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        uart_rx_pad,
    input  logic        baud_tick_16x,
    pb_uart_rx_if.slave rx_port
);
    localparam int unsigned       DEPTH      = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]  COUNT_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]  INT_THRESH = INT_LEVEL[FIFO_AW:0];

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef PB_UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif

    logic               sync_q1;
    logic               rx_s;
    logic               armed;
    logic [2:0]         state;
    logic [3:0]         tick_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               int_q;
    logic               overrun;
    logic               frame_err;

    logic               full_bit;
    logic               stop_sample;
    logic               push_req;
    logic               frame_bad;
    logic               empty;
    logic               full;
    logic               do_push;
    logic               do_pop;
    logic               set_overrun;

    assign full_bit    = baud_tick_16x && (tick_cnt == 4'd15);
    assign stop_sample = (state == ST_STOP) && full_bit;
    assign push_req    = stop_sample && rx_s;
    assign frame_bad   = stop_sample && !rx_s;

    assign empty       = (count == '0);
    assign full        = (count == COUNT_FULL);
    assign do_pop      = rx_port.uart_rx_read && !empty;
    // A full FIFO still accepts a byte when the same cycle frees a slot.
    assign do_push     = push_req && (!full || do_pop);
    assign set_overrun = push_req && full && !do_pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q1  <= 1'b1;
            rx_s     <= 1'b1;
            armed    <= 1'b1;
            state    <= ST_IDLE;
            tick_cnt <= 4'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'h00;
        end else begin
            sync_q1 <= uart_rx_pad;
            rx_s    <= sync_q1;
            case (state)
                ST_IDLE: begin
                    // Line must be seen high after a frame before a new start counts.
                    if (rx_s) armed <= 1'b1;
                    if (baud_tick_16x && !rx_s && armed) begin
                        state    <= ST_START;
                        tick_cnt <= 4'd0;
                        armed    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_tick_16x) begin
                        if (tick_cnt == 4'd7) begin
                            tick_cnt <= 4'd0;
                            if (rx_s) begin
                                state <= ST_IDLE;
                            end else begin
                                state   <= ST_DATA;
                                bit_idx <= 3'd0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (baud_tick_16x) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            shift   <= {rx_s, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
`ifdef PB_UART_RX_PARITY_EN
                                state <= ST_PARITY;
`else
                                state <= ST_STOP;
`endif
                            end
                        end
                    end
                end
`ifdef PB_UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (baud_tick_16x) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_tick_16x) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage is not reset; only pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (FIFO_AW)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (FIFO_AW)'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flags: a new error in the clearing cycle wins over the clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            int_q     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            int_q     <= (count >= INT_THRESH);
            overrun   <= set_overrun | (overrun & ~rx_port.uart_rx_clear);
            frame_err <= frame_bad | (frame_err & ~rx_port.uart_rx_clear);
        end
    end

`ifdef PB_UART_RX_PARITY_EN
    logic parity_sample;
    logic parity_bad;
    logic parity_err;

    assign parity_sample = (state == ST_PARITY) && full_bit;
    assign parity_bad    = parity_sample && ((^shift ^ rx_s) != rx_port.uart_rx_parity_odd);

    always_ff @(posedge clk_i) begin
        if (rst_i) parity_err <= 1'b0;
        else       parity_err <= parity_bad | (parity_err & ~rx_port.uart_rx_clear);
    end

    assign rx_port.uart_rx_parity_err = parity_err;
`endif

    assign rx_port.uart_rx_data      = empty ? 8'h00 : mem[rd_ptr];
    assign rx_port.uart_rx_int       = int_q;
    assign rx_port.uart_rx_count     = count;
    assign rx_port.uart_rx_empty     = empty;
    assign rx_port.uart_rx_full      = full;
    assign rx_port.uart_rx_overrun   = overrun;
    assign rx_port.uart_rx_frame_err = frame_err;
endmodule
